// File: rtl/atm_pin_verifier.sv
// PIN entry and verification stage for the ATM controller: collects keypad digits,
// compares them with the card's PIN and enforces an attempt limit. Optional macro: PIN_TIMEOUT_EN.
module atm_pin_verifier #(
  parameter int unsigned PIN_DIGITS  = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  localparam int unsigned PIN_W = PIN_DIGITS * DIGIT_W,
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1),
  localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_inserted,
  input  logic [PIN_W-1:0] stored_pin,
  input  logic             digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic             digit_ready,
  input  logic             enter,
  input  logic             clear,
  output logic             pin_done,
  output logic             pin_correct,
  output logic             card_locked,
  output logic [TRY_W-1:0] tries_left,
  output logic [CNT_W-1:0] digit_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VERIFY,
    S_GRANTED,
    S_LOCKED
  } state_t;

  state_t             state, state_n;
  logic [PIN_W-1:0]   pin_buf, buf_n;
  logic [CNT_W-1:0]   count_n;
  logic [TRY_W-1:0]   tries_n, tries_dec;
  logic               ready_n, done_n, correct_n, locked_n;
  logic               digit_ok;

`ifdef PIN_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0]   timer, timer_n;

  // Idle-cycle counter; only advances while waiting in COLLECT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= '0;
    else     timer <= timer_n;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    buf_n     = pin_buf;
    count_n   = digit_count;
    tries_n   = tries_left;
    done_n    = 1'b0;
    correct_n = pin_correct;
    locked_n  = card_locked;
    tries_dec = (tries_left == '0) ? '0 : tries_left - TRY_W'(1);
    digit_ok  = digit_valid && digit_ready && (digit <= DIGIT_W'(9));
`ifdef PIN_TIMEOUT_EN
    timer_n   = '0;
`endif

    if (state != S_IDLE && !card_inserted) begin
      // Card pulled: abandon everything, including a pending verify result
      state_n   = S_IDLE;
      buf_n     = '0;
      count_n   = '0;
      tries_n   = TRY_W'(MAX_TRIES);
      correct_n = 1'b0;
      locked_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (card_inserted) begin
            state_n = S_COLLECT;
            buf_n   = '0;
            count_n = '0;
            tries_n = TRY_W'(MAX_TRIES);
          end
        end
        S_COLLECT: begin
          if (clear) begin
            count_n = '0;
          end else if (enter && digit_count == CNT_W'(PIN_DIGITS)) begin
            state_n = S_VERIFY;
          end else if (digit_ok) begin
            buf_n   = {pin_buf[PIN_W-DIGIT_W-1:0], digit};
            count_n = digit_count + CNT_W'(1);
          end else begin
`ifdef PIN_TIMEOUT_EN
            if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
              count_n = '0;
              tries_n = tries_dec;
              if (tries_dec == '0) begin
                state_n  = S_LOCKED;
                locked_n = 1'b1;
              end
            end else begin
              timer_n = timer + TMR_W'(1);
            end
`endif
          end
        end
        S_VERIFY: begin
          done_n = 1'b1;
          if (pin_buf == stored_pin) begin
            state_n   = S_GRANTED;
            correct_n = 1'b1;
          end else begin
            tries_n = tries_dec;
            count_n = '0;
            if (tries_dec == '0) begin
              state_n  = S_LOCKED;
              locked_n = 1'b1;
            end else begin
              state_n = S_COLLECT;
            end
          end
        end
        default: ;
      endcase
    end

    ready_n = (state_n == S_COLLECT) && (count_n < CNT_W'(PIN_DIGITS));
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pin_buf     <= '0;
      digit_count <= '0;
      tries_left  <= TRY_W'(MAX_TRIES);
      digit_ready <= 1'b0;
      pin_done    <= 1'b0;
      pin_correct <= 1'b0;
      card_locked <= 1'b0;
    end else begin
      state       <= state_n;
      pin_buf     <= buf_n;
      digit_count <= count_n;
      tries_left  <= tries_n;
      digit_ready <= ready_n;
      pin_done    <= done_n;
      pin_correct <= correct_n;
      card_locked <= locked_n;
    end
  end

endmodule

// File: doc/atm_pin_verifier.md
Name: atm_pin_verifier

Overview:
Upstream stage of the ATM controller FSM. Collects PIN digits from the keypad over a valid/ready handshake and compares them against the card's stored PIN. Counts failed attempts and locks the session after MAX_TRIES failures. Produces the pin_correct level that the controller samples in its CHECK_PIN state.

Parameters:
PIN_DIGITS, 4, number of digits in a PIN
DIGIT_W, 4, width of one BCD digit
MAX_TRIES, 3, failed attempts allowed before lock
TIMEOUT_CYC, 1000, idle cycles allowed in COLLECT (used only with PIN_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
card_inserted  in  1  level; card present in reader
stored_pin  in  PIN_DIGITS*DIGIT_W  reference PIN; first digit in the MS nibble; stable while card_inserted
digit_valid  in  1  keypad digit offered
digit  in  DIGIT_W  BCD digit value
digit_ready  out  1  block can accept a digit
enter  in  1  submit-entry strobe
clear  in  1  discard partial entry
pin_done  out  1  one-cycle pulse; a verification result is available
pin_correct  out  1  result level; held until card removal
card_locked  out  1  attempt limit reached
tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts
digit_count  out  $clog2(PIN_DIGITS+1)  digits currently buffered

Behaviour:
- Reset values: digit_ready=0, pin_done=0, pin_correct=0, card_locked=0, digit_count=0, tries_left=MAX_TRIES, state IDLE, digit buffer zeroed.
- States: IDLE, COLLECT, VERIFY, GRANTED, LOCKED.
- IDLE: card_inserted=1 -> COLLECT at the next edge; tries_left=MAX_TRIES; buffer cleared.
- COLLECT: digit_ready = (digit_count < PIN_DIGITS).
- A digit is accepted on an edge where digit_valid && digit_ready && digit <= 9. Digits 10-15 are dropped and digit_count does not change.
- Accepted digits shift in MS-first; digit_count increments.
- clear=1 -> digit_count=0. clear takes priority over a digit offered in the same cycle.
- enter while digit_count==PIN_DIGITS -> VERIFY. enter with fewer digits is ignored.
- enter and clear in the same cycle: clear wins and enter is ignored.
- VERIFY lasts one cycle; the buffer is compared with stored_pin. At the edge leaving VERIFY:
  - pin_done=1 for exactly one cycle; pin_correct = match.
  - Match -> GRANTED.
  - Mismatch -> tries_left decrements. If the new value is 0 -> LOCKED, card_locked=1. Otherwise -> COLLECT with digit_count=0.
- Latency: enter accepted at edge N; pin_done/pin_correct visible after edge N+1.
- GRANTED: digit_ready=0; pin_correct held at 1; keypad input ignored.
- LOCKED: digit_ready=0; card_locked held at 1; pin_correct=0; keypad input ignored.
- A failed attempt leaves pin_correct at 0 (it was already 0).
- Card removal: card_inserted=0 in any non-IDLE state -> IDLE at the next edge. Outputs return to their reset values, except pin_done, which is not pulsed.
- Removal in VERIFY: removal wins; no pin_done pulse is issued.
- Async rst mid-operation: immediate return to reset values regardless of state.
- tries_left never underflows; it is clamped at 0.

Optional Feature:
PIN_TIMEOUT_EN
- Defined: a cycle counter runs in COLLECT. It resets on entry to COLLECT, on each accepted digit and on clear. At TIMEOUT_CYC consecutive idle cycles the state returns to COLLECT with digit_count=0 and tries_left decremented, counted as one failed attempt. When tries_left reaches 0 this way -> LOCKED. No pin_done pulse on timeout.
- Undefined: no counter logic is synthesised; COLLECT waits indefinitely.

Test Plan:
- stored_pin=16'h1234; insert card; key 1,2,3,4; enter -> pin_done pulses 1 cycle after the enter edge; pin_correct=1; state GRANTED; tries_left=3.
- stored_pin=16'h1234; enter 1,2,3,5 three times -> tries_left steps 2,1,0; three pin_done pulses with pin_correct=0; card_locked=1 after the third; digit_ready=0.
- Key 1,2 then clear, then 1,2,3,4, enter -> digit_count 2->0->4; match. Digit 4'hA offered mid-entry -> ignored, digit_count unchanged.
- Key 1,2,3 then enter -> ignored, no pin_done. Fifth digit offered with count=4 -> digit_ready=0, not accepted.
- In GRANTED, drop card_inserted -> next edge IDLE; pin_correct=0, tries_left=3. Assert rst in COLLECT -> all outputs reset at once.
- With PIN_TIMEOUT_EN, TIMEOUT_CYC=20: key 1,2 then idle 20 cycles -> digit_count=0, tries_left=2, no pin_done.
